// File: rtl/mod163841_pkg.sv
// Shared constants and datapath types for the mod-163841 multiplier pipeline.
package mod163841_pkg;
  localparam int Q       = 163841;
  localparam int QH      = 81920;
  localparam int OPW     = 18;
  localparam int PRODW   = 35;
  localparam int RESW    = 18;
  localparam int RED_LAT = 3;

  typedef logic signed [OPW-1:0]   opnd_t;
  typedef logic signed [PRODW-1:0] prod_t;
  typedef logic signed [RESW-1:0]  res_t;
endpackage

// File: rtl/modmul163841s.sv
// Three-stage signed Barrett reducer: centered (inZ mod 163841) appears 3 edges after inZ.
module modmul163841s
  import mod163841_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  prod_t inZ,
  output res_t  outZ
);
  // 2^52/Q keeps the quotient estimate within one of floor(x/Q) for |x| < 2^34.
  localparam int                   BRT_K   = 52;
  localparam longint unsigned      BRT_M_U = (64'd1 << BRT_K) / 64'(Q);
  localparam logic signed [36:0]   BRT_M   = 37'(BRT_M_U);
  localparam logic signed [19:0]   Q_S     = 20'(Q);
  localparam logic signed [19:0]   QH_S    = 20'(QH);

  // Remainder estimate lies in [-Q, 2Q); fold into [0, Q) then center.
  function automatic res_t center(input logic signed [19:0] r);
    logic signed [19:0] t;
    t = r;
    if (t < 0)
      t = t + Q_S;
    else if (t >= Q_S)
      t = t - Q_S;
    if (t > QH_S)
      t = t - Q_S;
    return res_t'(t);
  endfunction

  prod_t              x_p0;
  logic signed [19:0] q_p0;
  logic signed [19:0] r_p1;
  res_t               z_p2;

  // stage p0: quotient estimate
  always_ff @(posedge clk) begin
    x_p0 <= inZ;
    q_p0 <= 20'((72'(inZ) * 72'(BRT_M)) >>> BRT_K);
  end

  // stage p1: coarse remainder
  always_ff @(posedge clk) begin
    r_p1 <= 20'(40'(x_p0) - 40'(q_p0) * 40'(Q_S));
  end

  // stage p2: final correction and centering
  always_ff @(posedge clk) begin
    if (rst)
      z_p2 <= '0;
    else
      z_p2 <= center(r_p1);
  end

  assign outZ = z_p2;
endmodule

// File: rtl/res_fifo.sv
// Synchronous result FIFO; full/empty derive from the occupancy count, head reads as zero when empty.
module res_fifo #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_rd;

  assign do_rd   = rd_en & (count != '0);
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/modmul163841_pipe.sv
// Streaming centered modular multiplier mod 163841 with credit-controlled output FIFO.
module modmul163841_pipe
  import mod163841_pkg::*;
#(
  parameter int TAGW       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [OPW-1:0] inA,
  input  logic signed [OPW-1:0] inB,
  input  logic [TAGW-1:0]       inTag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [RESW-1:0] outZ,
  output logic [TAGW-1:0]       outTag
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = RESW + TAGW;

  logic [CW-1:0]   credit;
  logic [CW-1:0]   fifo_count;
  logic [FW-1:0]   fifo_rd;
  logic            accept;
  logic            pop;
  prod_t           prod_p0;
  res_t            red_z;
  logic            vld_p0, vld_p1, vld_p2, vld_p3;
  logic [TAGW-1:0] tag_p0, tag_p1, tag_p2, tag_p3;

  // A same-cycle pop is deliberately ignored so in_ready depends only on registers and rst.
  assign in_ready  = rst & (credit < CW'(FIFO_DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;

  // stage p0: product register; tags follow the reducer latency
  always_ff @(posedge clk) begin
    prod_p0 <= PRODW'(inA) * PRODW'(inB);
    tag_p0  <= inTag;
    tag_p1  <= tag_p0;
    tag_p2  <= tag_p1;
    tag_p3  <= tag_p2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      credit <= '0;
    else begin
      case ({accept, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  modmul163841s u_red (
    .clk  (clk),
    .rst  (~rst),
    .inZ  (prod_p0),
    .outZ (red_z)
  );

  // stage p3 -> FIFO: reducer output lines up with vld_p3/tag_p3
  res_fifo #(
    .DATA_W (FW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (~rst),
    .wr_en   (vld_p3),
    .wr_data ({red_z, tag_p3}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  assign outZ   = fifo_rd[FW-1:TAGW];
  assign outTag = fifo_rd[TAGW-1:0];
endmodule
